// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus type, stage
// indices and the divider / trap sequencer state encodings.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_BUS_W = 7;
  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  typedef enum logic [2:0] {
    ST_PC   = 3'd0,
    ST_IF1  = 3'd1,
    ST_IF2  = 3'd2,
    ST_ID   = 3'd3,
    ST_EX   = 3'd4,
    ST_MEM1 = 3'd5,
    ST_MEM2 = 3'd6
  } stage_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_BUSY,
    D_LAST
  } div_state_e;

  typedef enum logic [1:0] {
    T_RUN,
    T_FLUSH,
    T_WAIT
  } trap_state_e;

  // Stages 0..top hold; the stage after top receives a bubble.
  function automatic stall_bus_t hold_through(input stage_e top);
    stall_bus_t m;
    m = '0;
    for (int unsigned i = 0; i < STALL_BUS_W; i++) begin
      if (i <= int'(top)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Iterative-divider sequencer: keeps EX occupied for one divide and paces
// the divider iterations, freezing the step count while the dcache stalls.
module div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic hold,
  output logic busy,
  output logic step,
  output logic last
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state <= D_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      step  <= 1'b0;
      last  <= 1'b0;
    end else begin
      case (state)
        D_IDLE: begin
          if (start) begin
            state <= D_BUSY;
            cnt   <= CNT_W'(DIV_LAT - 1);
            busy  <= 1'b1;
            step  <= 1'b1;
          end
        end
        D_BUSY: begin
          if (!hold) begin
            cnt <= cnt - 1'b1;
            // Busy mask drops with the final step so EX advances right after it.
            if (cnt == CNT_W'(1)) begin
              state <= D_LAST;
              busy  <= 1'b0;
              last  <= 1'b1;
            end
          end
        end
        D_LAST: begin
          state <= D_IDLE;
          step  <= 1'b0;
          last  <= 1'b0;
        end
        default: begin
          state <= D_IDLE;
          busy  <= 1'b0;
          step  <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central controller for the 7-stage pipeline: stall vector from hazard
// masks, divider sequencing and the trap flush / redirect handshake.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W = 7,
  parameter int unsigned DIV_LAT = 33,
  parameter int unsigned CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               ex_load,
  input  logic [4:0]         ex_rd,
  input  logic               mem1_load,
  input  logic [4:0]         mem1_rd,
  input  logic               ex_div_start,
  input  logic               icache_stall,
  input  logic               dcache_stall,
  input  logic               trap_req,
  input  logic [31:0]        trap_pc,
  input  logic               redirect_ack,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               redirect_e,
  output logic [31:0]        redirect_pc,
  output logic               div_step,
  output logic               div_last
);

  trap_state_e trap_state;
  logic        live;
  logic        pc_hold;
  logic        div_busy;
  logic        div_abort;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        load_use;
  stall_bus_t  stall_bus;

  // Masks from stage registers are unknown until one clean cycle after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_state  <= T_RUN;
      redirect_pc <= '0;
      flush       <= 1'b0;
      redirect_e  <= 1'b0;
      pc_hold     <= 1'b0;
    end else begin
      case (trap_state)
        T_RUN: begin
          if (trap_req) begin
            trap_state  <= T_FLUSH;
            redirect_pc <= trap_pc;
            flush       <= 1'b1;
            redirect_e  <= 1'b1;
          end
        end
        T_FLUSH: begin
          flush <= 1'b0;
          if (redirect_ack) begin
            trap_state <= T_RUN;
            redirect_e <= 1'b0;
          end else begin
            trap_state <= T_WAIT;
            pc_hold    <= 1'b1;
          end
        end
        T_WAIT: begin
          if (redirect_ack) begin
            trap_state <= T_RUN;
            redirect_e <= 1'b0;
            pc_hold    <= 1'b0;
          end
        end
        default: begin
          trap_state <= T_RUN;
          flush      <= 1'b0;
          redirect_e <= 1'b0;
          pc_hold    <= 1'b0;
        end
      endcase
    end
  end

  // A divide in flight is killed by the trap that will flush it.
  assign div_abort = (trap_state == T_RUN && trap_req) || trap_state == T_FLUSH;

  div_seq #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_div_start),
    .abort (div_abort),
    .hold  (dcache_stall),
    .busy  (div_busy),
    .step  (div_step),
    .last  (div_last)
  );

  assign rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                   ((ex_load && ex_rd == id_rs1) || (mem1_load && mem1_rd == id_rs1));
  assign rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                   ((ex_load && ex_rd == id_rs2) || (mem1_load && mem1_rd == id_rs2));
  assign load_use = id_valid && (rs1_hit || rs2_hit);

  always_comb begin
    stall_bus = '0;
    if (pc_hold)      stall_bus = stall_bus | hold_through(ST_PC);
    if (icache_stall) stall_bus = stall_bus | hold_through(ST_IF1);
    if (load_use)     stall_bus = stall_bus | hold_through(ST_ID);
    if (div_busy)     stall_bus = stall_bus | hold_through(ST_EX);
    if (dcache_stall) stall_bus = stall_bus | hold_through(ST_MEM1);
    if (flush || !live) stall_bus = '0;
  end

  assign stall = stall_bus;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_load;
  logic [4:0]  ex_rd;
  logic        mem1_load;
  logic [4:0]  mem1_rd;
  logic        ex_div_start;
  logic        icache_stall, dcache_stall;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic        redirect_ack;
  logic [6:0]  stall;
  logic        flush, redirect_e;
  logic [31:0] redirect_pc;
  logic        div_step, div_last;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(
    .STALL_W (7),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_load      (ex_load),
    .ex_rd        (ex_rd),
    .mem1_load    (mem1_load),
    .mem1_rd      (mem1_rd),
    .ex_div_start (ex_div_start),
    .icache_stall (icache_stall),
    .dcache_stall (dcache_stall),
    .trap_req     (trap_req),
    .trap_pc      (trap_pc),
    .redirect_ack (redirect_ack),
    .stall        (stall),
    .flush        (flush),
    .redirect_e   (redirect_e),
    .redirect_pc  (redirect_pc),
    .div_step     (div_step),
    .div_last     (div_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_load = 0; ex_rd = 0; mem1_load = 0; mem1_rd = 0; ex_div_start = 0;
    icache_stall = 0; dcache_stall = 0; trap_req = 0; trap_pc = 0; redirect_ack = 0;
  endtask

  // Behavioural model: div_rem = -1 idle, >0 progress cycles left, 0 final cycle.
  int          div_rem   = -1;
  bit          flushing  = 0;
  bit          waiting   = 0;
  bit          live_m    = 0;
  bit          model_ok  = 0;
  logic [31:0] pc_m      = '0;

  function automatic bit src_hit(input logic use_f, input logic [4:0] rs);
    return use_f && rs != 0 &&
           ((ex_load && ex_rd == rs) || (mem1_load && mem1_rd == rs));
  endfunction

  initial begin
    forever begin
      int         top;
      logic [6:0] exp_stall;
      bit         take;
      @(negedge clk);
      if (model_ok) begin
        top = -1;
        if (waiting) top = 0;
        if (icache_stall) top = 1;
        if (id_valid && (src_hit(id_use_rs1, id_rs1) || src_hit(id_use_rs2, id_rs2))) top = 3;
        if (div_rem > 0) top = 4;
        if (dcache_stall) top = 5;
        exp_stall = (top < 0) ? 7'd0 : 7'((1 << (top + 1)) - 1);
        if (!live_m || flushing) exp_stall = '0;
        chk("m_stall", 32'(stall), 32'(exp_stall));
        chk("m_flush", 32'(flush), 32'(flushing));
        chk("m_redirect_e", 32'(redirect_e), 32'(flushing || waiting));
        chk("m_redirect_pc", redirect_pc, pc_m);
        chk("m_div_step", 32'(div_step), 32'(div_rem >= 0));
        chk("m_div_last", 32'(div_last), 32'(div_rem == 0));
      end
      if (!rst_n) begin
        div_rem = -1; flushing = 0; waiting = 0; live_m = 0; pc_m = '0;
        model_ok = 1;
      end else begin
        take = trap_req && !flushing && !waiting;
        if (take || flushing)              div_rem = -1;
        else if (div_rem < 0 && ex_div_start) div_rem = DIV_LAT - 1;
        else if (div_rem > 0 && !dcache_stall) div_rem = div_rem - 1;
        else if (div_rem == 0)             div_rem = -1;
        if (take) begin
          pc_m = trap_pc; flushing = 1;
        end else if (flushing) begin
          flushing = 0; waiting = !redirect_ack;
        end else if (waiting && redirect_ack) begin
          waiting = 0;
        end
        live_m = 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones, last_cnt, last_at_drop, done;
    idle_inputs();
    rst_n = 0;
    next_cycle(); next_cycle();
    rst_n = 1;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_redirect", 32'({flush, redirect_e, div_step, div_last}), 32'h0);
    chk("rst_pc", redirect_pc, 32'h0);
    next_cycle();

    // Load immediately followed by its consumer: two stall cycles.
    id_valid = 1; id_rs1 = 5; id_use_rs1 = 1; ex_load = 1; ex_rd = 5;
    @(negedge clk); chk("lu_d1_a", 32'(stall), 32'b0001111);
    next_cycle();
    ex_load = 0; mem1_load = 1; mem1_rd = 5;
    @(negedge clk); chk("lu_d1_b", 32'(stall), 32'b0001111);
    next_cycle();
    mem1_load = 0;
    @(negedge clk); chk("lu_d1_c", 32'(stall), 32'h0);
    next_cycle();

    idle_inputs();
    id_valid = 1; id_rs1 = 0; id_use_rs1 = 1; ex_load = 1; ex_rd = 0;
    @(negedge clk); chk("lu_x0", 32'(stall), 32'h0);
    next_cycle();

    idle_inputs();
    icache_stall = 1; dcache_stall = 1;
    @(negedge clk); chk("overlap", 32'(stall), 32'b0111111);
    next_cycle();

    // Divide with a 3-cycle dcache miss part-way through.
    idle_inputs();
    ex_div_start = 1;
    next_cycle();
    ex_div_start = 0;
    ones = 0; last_cnt = 0; last_at_drop = 0; done = 0;
    for (int i = 1; i < 80 && done == 0; i++) begin
      dcache_stall = (i >= 10 && i < 13);
      @(negedge clk);
      if (div_last) last_cnt++;
      if (stall[4]) ones++;
      else begin
        if (div_last) last_at_drop = 1;
        done = 1;
      end
      next_cycle();
    end
    dcache_stall = 0;
    chk("div_done", 32'(done), 32'd1);
    chk("div_busy_len", 32'(ones), 32'd35);
    chk("div_last_cnt", 32'(last_cnt), 32'd1);
    chk("div_last_at_drop", 32'(last_at_drop), 32'd1);
    next_cycle();

    // Trap while the divider is busy.
    ex_div_start = 1;
    next_cycle();
    ex_div_start = 0;
    next_cycle(); next_cycle(); next_cycle();
    trap_req = 1; trap_pc = 32'h8000_0100;
    next_cycle();
    trap_req = 0; trap_pc = 0;
    @(negedge clk);
    chk("trap_flush", 32'(flush), 32'd1);
    chk("trap_stall", 32'(stall), 32'h0);
    chk("trap_div_idle", 32'(div_step), 32'd0);
    chk("trap_pc", redirect_pc, 32'h8000_0100);
    chk("trap_redirect_e", 32'(redirect_e), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      next_cycle();
      redirect_ack = (k == 4);
      @(negedge clk);
      chk("wait_redirect_e", 32'(redirect_e), 32'd1);
      chk("wait_stall", 32'(stall), 32'b0000001);
    end
    next_cycle();
    redirect_ack = 0;
    @(negedge clk);
    chk("acked_redirect_e", 32'(redirect_e), 32'd0);
    chk("acked_stall", 32'(stall), 32'h0);
    next_cycle();

    // Reset while waiting for redirect with a divide in flight.
    trap_req = 1; trap_pc = 32'h0000_4000;
    next_cycle();
    trap_req = 0; trap_pc = 0;
    next_cycle();
    ex_div_start = 1;
    next_cycle();
    ex_div_start = 0;
    @(negedge clk);
    chk("pre_rst_stall", 32'(stall), 32'b0011111);
    chk("pre_rst_busy", 32'({redirect_e, div_step}), 32'b11);
    next_cycle();
    rst_n = 0;
    next_cycle();
    @(negedge clk);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_outs", 32'({flush, redirect_e, div_step, div_last}), 32'h0);
    chk("rst_mid_pc", redirect_pc, 32'h0);
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    chk("rst_rel_outs", 32'({stall, flush, redirect_e, div_step, div_last}), 32'h0);
    next_cycle();

    // Randomized traffic; small register range keeps hazards frequent.
    for (int c = 0; c < 4000; c++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_load      = ($urandom_range(0, 2) == 0);
      ex_rd        = 5'($urandom_range(0, 3));
      mem1_load    = ($urandom_range(0, 2) == 0);
      mem1_rd      = 5'($urandom_range(0, 3));
      ex_div_start = ($urandom_range(0, 15) == 0);
      icache_stall = ($urandom_range(0, 4) == 0);
      dcache_stall = ($urandom_range(0, 5) == 0);
      trap_req     = ($urandom_range(0, 59) == 0);
      trap_pc      = $urandom;
      redirect_ack = ($urandom_range(0, 2) == 0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
